// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - signal bundle between the sequencer, memories and decoder
interface instr_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  // Launch control and instruction-memory read data
  logic             Start;
  logic [8:0]       InstrIn;
  // Decoder / ALU indications for the instruction held in Instr
  logic             Branch;
  logic             Taken;
  logic [PC_W-1:0]  Target;
  logic             MemOp;
  logic             Halt;
  // Data-memory completion
  logic             MemReady;
  // Sequencer outputs
  logic [PC_W-1:0]  PC;
  logic [8:0]       Instr;
  logic             MemReq;
  logic             Retire;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] InstrCount;

  // Sequencer side
  modport master (
    input  Start, InstrIn, Branch, Taken, Target, MemOp, Halt, MemReady,
    output PC, Instr, MemReq, Retire, Busy, Done, InstrCount
  );

  // Environment side: memories, decoder, ALU and launch logic
  modport slave (
    output Start, InstrIn, Branch, Taken, Target, MemOp, Halt, MemReady,
    input  PC, Instr, MemReq, Retire, Busy, Done, InstrCount
  );
endinterface

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/execute sequencer owning PC and instruction register
module instr_sequencer #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic              Clk,
  input  logic              ResetN,
  instr_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXEC    = 3'd2,
    S_MEMWAIT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [8:0]       instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             retire;
  logic             mem_req;
  logic [PC_W-1:0]  pc_next;
  logic [CNT_W-1:0] cnt_next;

  // Handshake strobes decode from state plus live decoder/memory inputs so a
  // ready memory can complete in the same cycle the request is raised.
  always_comb begin
    mem_req = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_EXEC: begin
        if (!bus.Halt) begin
          if (bus.MemOp) begin
            mem_req = 1'b1;
            retire  = bus.MemReady;
          end else begin
            retire  = 1'b1;
          end
        end
      end
      S_MEMWAIT: begin
        mem_req = 1'b1;
        retire  = bus.MemReady;
      end
      default: begin
        mem_req = 1'b0;
        retire  = 1'b0;
      end
    endcase
  end

  // Next PC and saturating retire count, used only on a retiring cycle.
  always_comb begin
    pc_next  = (bus.Branch && bus.Taken) ? bus.Target : pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    cnt_next = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Next-state decode for the FSM and the architectural registers.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.Start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        instr_d = bus.InstrIn;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (bus.Halt) begin
          state_d = S_DONE;
        end else if (bus.MemOp && !bus.MemReady) begin
          state_d = S_MEMWAIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMWAIT: begin
        if (bus.MemReady) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (retire) begin
      pc_d  = pc_next;
      cnt_d = cnt_next;
    end
  end

  // State and architectural registers; reset may land mid-instruction.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output mapping.
  always_comb begin
    bus.PC         = pc_q;
    bus.Instr      = instr_q;
    bus.InstrCount = cnt_q;
    bus.MemReq     = mem_req;
    bus.Retire     = retire;
    bus.Busy       = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEMWAIT);
    bus.Done       = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
module tb_instr_sequencer;
  localparam int PC_W  = 10;
  localparam int CNT_W = 4;
  localparam int MAXC  = 512;
  localparam int K_ALU = 0;
  localparam int K_BR  = 1;
  localparam int K_MEM = 2;
  localparam int K_HALT = 3;
  // Observation word: {pc[26:17], instr[16:8], cnt[7:4], busy, done, retire, memreq}
  localparam logic [26:0] NOI = {10'h3FF, 9'h000, 8'hFF};
  localparam logic [26:0] ALL = {27{1'b1}};

  typedef struct {
    int              kind;
    bit              taken;
    logic [PC_W-1:0] target;
    int              wait_n;
    logic [8:0]      instr;
  } step_t;

  typedef struct {
    logic            start;
    logic [8:0]      instr_in;
    logic            branch;
    logic            taken;
    logic [PC_W-1:0] target;
    logic            memop;
    logic            memready;
    logic            halt;
    logic [26:0]     exp;
    logic [26:0]     mask;
  } cyc_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  instr_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus();

  instr_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .Clk    (clk),
    .ResetN (resetn),
    .bus    (bus.master)
  );

  step_t           prog[$];
  cyc_t            sched[MAXC];
  logic [26:0]     obs[MAXC];
  int              ncyc;
  logic [PC_W-1:0] model_pc;
  logic [CNT_W-1:0] model_cnt;
  logic            model_done;
  int              errors = 0;
  int              checks = 0;

  function automatic logic [26:0] pack(input logic [9:0] pc, input logic [8:0] ins,
                                       input logic [3:0] cnt, input logic busy,
                                       input logic done, input logic ret, input logic req);
    return {pc, ins, cnt, busy, done, ret, req};
  endfunction

  function automatic step_t mk(input int kind, input bit taken, input int target, input int wait_n);
    step_t s;
    s.kind   = kind;
    s.taken  = taken;
    s.target = PC_W'(target);
    s.wait_n = wait_n;
    s.instr  = 9'($urandom);
    return s;
  endfunction

  task automatic rand_cycle(input int c);
    sched[c].start    = 1'($urandom);
    sched[c].instr_in = 9'($urandom);
    sched[c].branch   = 1'($urandom);
    sched[c].taken    = 1'($urandom);
    sched[c].target   = PC_W'($urandom);
    sched[c].memop    = 1'($urandom);
    sched[c].memready = 1'($urandom);
    sched[c].halt     = 1'($urandom);
    sched[c].exp      = '0;
    sched[c].mask     = NOI;
  endtask

  // Program-level model: each step costs FETCH + EXEC (+ waits), retires update PC/count.
  task automatic build(input bit hold);
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cnt;
    int c;
    bit halted;
    bit last;
    pc = model_pc;
    cnt = model_cnt;
    halted = 1'b0;
    rand_cycle(0);
    sched[0].start = 1'b1;
    sched[0].exp = pack(pc, 9'h000, cnt, 1'b0, model_done, 1'b0, 1'b0);
    pc = '0;
    cnt = '0;
    c = 1;
    for (int i = 0; i < prog.size() && !halted; i++) begin
      rand_cycle(c);
      if (hold) sched[c].start = 1'b1;
      sched[c].instr_in = prog[i].instr;
      sched[c].exp = pack(pc, 9'h000, cnt, 1'b1, 1'b0, 1'b0, 1'b0);
      c++;
      if (prog[i].kind == K_HALT) begin
        rand_cycle(c);
        if (hold) sched[c].start = 1'b1;
        sched[c].halt = 1'b1;
        sched[c].exp  = pack(pc, prog[i].instr, cnt, 1'b1, 1'b0, 1'b0, 1'b0);
        sched[c].mask = ALL;
        c++;
        halted = 1'b1;
      end else if (prog[i].kind == K_MEM) begin
        for (int w = 0; w <= prog[i].wait_n; w++) begin
          last = (w == prog[i].wait_n);
          rand_cycle(c);
          if (hold) sched[c].start = 1'b1;
          sched[c].halt     = 1'b0;
          sched[c].memop    = 1'b1;
          sched[c].memready = last;
          if (last) sched[c].branch = 1'b0;
          sched[c].exp  = pack(pc, prog[i].instr, cnt, 1'b1, 1'b0, last, 1'b1);
          sched[c].mask = ALL;
          c++;
        end
        pc = PC_W'(pc + 1);
        if (cnt != '1) cnt = cnt + 1'b1;
      end else begin
        rand_cycle(c);
        if (hold) sched[c].start = 1'b1;
        sched[c].halt   = 1'b0;
        sched[c].memop  = 1'b0;
        sched[c].branch = (prog[i].kind == K_BR);
        if (prog[i].kind == K_BR) begin
          sched[c].taken  = prog[i].taken;
          sched[c].target = prog[i].target;
        end
        sched[c].exp  = pack(pc, prog[i].instr, cnt, 1'b1, 1'b0, 1'b1, 1'b0);
        sched[c].mask = ALL;
        c++;
        if (prog[i].kind == K_BR && prog[i].taken) pc = prog[i].target;
        else pc = PC_W'(pc + 1);
        if (cnt != '1) cnt = cnt + 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      rand_cycle(c);
      sched[c].start = 1'b0;
      sched[c].exp = pack(pc, 9'h000, cnt, 1'b0, 1'b1, 1'b0, 1'b0);
      c++;
    end
    model_pc   = pc;
    model_cnt  = cnt;
    model_done = 1'b1;
    ncyc = c;
  endtask

  task automatic run_sched(input int upto);
    for (int c = 0; c < upto; c++) begin
      @(negedge clk);
      bus.Start    = sched[c].start;
      bus.InstrIn  = sched[c].instr_in;
      bus.Branch   = sched[c].branch;
      bus.Taken    = sched[c].taken;
      bus.Target   = sched[c].target;
      bus.MemOp    = sched[c].memop;
      bus.MemReady = sched[c].memready;
      bus.Halt     = sched[c].halt;
      #1;
      obs[c] = pack(bus.PC, bus.Instr, bus.InstrCount, bus.Busy, bus.Done, bus.Retire, bus.MemReq);
    end
  endtask

  task automatic do_reset;
    resetn       = 1'b0;
    bus.Start    = 1'b0;
    bus.InstrIn  = 9'h1A5;
    bus.Branch   = 1'b1;
    bus.Taken    = 1'b1;
    bus.Target   = 10'h155;
    bus.MemOp    = 1'b1;
    bus.MemReady = 1'b1;
    bus.Halt     = 1'b0;
    repeat (2) @(posedge clk);
    model_pc   = '0;
    model_cnt  = '0;
    model_done = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.PC !== 10'h000) begin errors++; $display("FAIL reset_pc got=%h want=000", bus.PC); end
    checks++;
    if (bus.Instr !== 9'h000) begin errors++; $display("FAIL reset_instr got=%h want=000", bus.Instr); end
    checks++;
    if (bus.InstrCount !== 4'h0) begin errors++; $display("FAIL reset_count got=%h want=0", bus.InstrCount); end
    checks++;
    if ({bus.Busy, bus.Done, bus.Retire, bus.MemReq} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b want=0000", {bus.Busy, bus.Done, bus.Retire, bus.MemReq});
    end
    resetn = 1'b1;
  endtask

  task automatic test_straight_line;
    prog.delete();
    for (int i = 0; i < 3; i++) prog.push_back(mk(K_ALU, 1'b0, 0, 0));
    prog.push_back(mk(K_HALT, 1'b0, 0, 0));
    build(1'b0);
    run_sched(ncyc);
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if ((obs[c] & sched[c].mask) !== sched[c].exp) begin
        errors++; $display("FAIL straight cyc=%0d got=%h want=%h", c, obs[c] & sched[c].mask, sched[c].exp);
      end
    end
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (obs[c][1] !== ((c == 2) || (c == 4) || (c == 6))) begin
        errors++; $display("FAIL straight_retire cyc=%0d got=%b", c, obs[c][1]);
      end
    end
    checks++;
    if (obs[9][2] !== 1'b1 || obs[8][2] !== 1'b0) begin
      errors++; $display("FAIL straight_done got=%b%b want=01", obs[8][2], obs[9][2]);
    end
    checks++;
    if (obs[9][26:17] !== 10'd3 || obs[9][7:4] !== 4'd3) begin
      errors++; $display("FAIL straight_final pc=%h cnt=%h want pc=003 cnt=3", obs[9][26:17], obs[9][7:4]);
    end
  endtask

  task automatic test_branch;
    for (int t = 1; t >= 0; t--) begin
      prog.delete();
      for (int i = 0; i < 4; i++) prog.push_back(mk(K_ALU, 1'b0, 0, 0));
      prog.push_back(mk(K_BR, t[0], 'h20, 0));
      prog.push_back(mk(K_ALU, 1'b0, 0, 0));
      prog.push_back(mk(K_HALT, 1'b0, 0, 0));
      build(1'b0);
      run_sched(ncyc);
      for (int c = 0; c < ncyc; c++) begin
        checks++;
        if ((obs[c] & sched[c].mask) !== sched[c].exp) begin
          errors++; $display("FAIL branch%0d cyc=%0d got=%h want=%h", t, c, obs[c] & sched[c].mask, sched[c].exp);
        end
      end
      checks++;
      if (obs[11][26:17] !== ((t == 1) ? 10'h020 : 10'h005)) begin
        errors++; $display("FAIL branch%0d_pc got=%h", t, obs[11][26:17]);
      end
    end
  endtask

  task automatic test_mem_wait;
    prog.delete();
    prog.push_back(mk(K_MEM, 1'b0, 0, 3));
    prog.push_back(mk(K_MEM, 1'b0, 0, 0));
    prog.push_back(mk(K_HALT, 1'b0, 0, 0));
    build(1'b0);
    run_sched(ncyc);
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if ((obs[c] & sched[c].mask) !== sched[c].exp) begin
        errors++; $display("FAIL memwait cyc=%0d got=%h want=%h", c, obs[c] & sched[c].mask, sched[c].exp);
      end
    end
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if ({obs[c][0], obs[c][1]} !== {((c >= 2 && c <= 5) || c == 7), (c == 5 || c == 7)}) begin
        errors++; $display("FAIL memwait_strobes cyc=%0d got req=%b ret=%b", c, obs[c][0], obs[c][1]);
      end
    end
    checks++;
    if (obs[6][26:17] !== 10'd1 || obs[8][26:17] !== 10'd2) begin
      errors++; $display("FAIL memwait_pc got=%h,%h want=001,002", obs[6][26:17], obs[8][26:17]);
    end
  endtask

  task automatic test_wrap;
    prog.delete();
    prog.push_back(mk(K_BR, 1'b1, 'h3FF, 0));
    for (int i = 0; i < 19; i++) prog.push_back(mk(K_ALU, 1'b0, 0, 0));
    prog.push_back(mk(K_HALT, 1'b0, 0, 0));
    build(1'b0);
    run_sched(ncyc);
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if ((obs[c] & sched[c].mask) !== sched[c].exp) begin
        errors++; $display("FAIL wrap cyc=%0d got=%h want=%h", c, obs[c] & sched[c].mask, sched[c].exp);
      end
    end
    checks++;
    if (obs[3][26:17] !== 10'h3FF || obs[5][26:17] !== 10'h000) begin
      errors++; $display("FAIL wrap_pc got=%h,%h want=3ff,000", obs[3][26:17], obs[5][26:17]);
    end
    checks++;
    if (obs[ncyc-1][7:4] !== 4'hF) begin
      errors++; $display("FAIL wrap_count_sat got=%h want=f", obs[ncyc-1][7:4]);
    end
  endtask

  task automatic gen_random(input int n);
    prog.delete();
    for (int i = 0; i < n - 1; i++) begin
      prog.push_back(mk($urandom_range(0, 2), 1'($urandom), $urandom_range(0, 1023), $urandom_range(0, 5)));
    end
    prog.push_back(mk(K_HALT, 1'b0, 0, 0));
  endtask

  task automatic test_start_busy;
    gen_random(12);
    build(1'b1);
    run_sched(ncyc);
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if ((obs[c] & sched[c].mask) !== sched[c].exp) begin
        errors++; $display("FAIL start_busy cyc=%0d got=%h want=%h", c, obs[c] & sched[c].mask, sched[c].exp);
      end
    end
  endtask

  task automatic test_relaunch;
    prog.delete();
    prog.push_back(mk(K_ALU, 1'b0, 0, 0));
    prog.push_back(mk(K_HALT, 1'b0, 0, 0));
    build(1'b0);
    run_sched(ncyc);
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if ((obs[c] & sched[c].mask) !== sched[c].exp) begin
        errors++; $display("FAIL relaunch cyc=%0d got=%h want=%h", c, obs[c] & sched[c].mask, sched[c].exp);
      end
    end
    checks++;
    if (obs[0][2] !== 1'b1 || obs[1][2] !== 1'b0 || obs[1][26:17] !== 10'h000 || obs[1][7:4] !== 4'h0) begin
      errors++; $display("FAIL relaunch_edge got done=%b%b pc=%h cnt=%h", obs[0][2], obs[1][2], obs[1][26:17], obs[1][7:4]);
    end
  endtask

  task automatic test_reset_mid_op;
    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back(mk(K_ALU, 1'b0, 0, 0));
    prog.push_back(mk(K_MEM, 1'b0, 0, 10));
    prog.push_back(mk(K_HALT, 1'b0, 0, 0));
    build(1'b0);
    run_sched(15);
    for (int c = 0; c < 15; c++) begin
      checks++;
      if ((obs[c] & sched[c].mask) !== sched[c].exp) begin
        errors++; $display("FAIL midreset_pre cyc=%0d got=%h want=%h", c, obs[c] & sched[c].mask, sched[c].exp);
      end
    end
    checks++;
    if (obs[14][26:17] !== 10'd5 || obs[14][0] !== 1'b1) begin
      errors++; $display("FAIL midreset_setup pc=%h req=%b want pc=005 req=1", obs[14][26:17], obs[14][0]);
    end
    @(negedge clk);
    resetn = 1'b0;
    bus.Start = 1'b0;
    bus.MemOp = 1'b1;
    bus.MemReady = 1'b0;
    bus.Halt = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.PC, bus.InstrCount, bus.Instr, bus.MemReq, bus.Busy, bus.Done, bus.Retire} !== '0) begin
      errors++; $display("FAIL midreset pc=%h cnt=%h instr=%h req=%b busy=%b done=%b ret=%b want all 0",
                         bus.PC, bus.InstrCount, bus.Instr, bus.MemReq, bus.Busy, bus.Done, bus.Retire);
    end
    resetn = 1'b1;
    model_pc = '0;
    model_cnt = '0;
    model_done = 1'b0;
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      gen_random($urandom_range(1, 25));
      build(1'($urandom));
      run_sched(ncyc);
      for (int c = 0; c < ncyc; c++) begin
        checks++;
        if ((obs[c] & sched[c].mask) !== sched[c].exp) begin
          errors++; $display("FAIL random%0d cyc=%0d got=%h want=%h", k, c, obs[c] & sched[c].mask, sched[c].exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_branch();
    test_mem_wait();
    test_wrap();
    test_start_busy();
    test_relaunch();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
